// File: rtl/pcfx_bios_loader.sv
// pcfx_bios_loader: buffers BIOS ioctl words and commits them to SDRAM.
// Optional running word checksum: define PCFX_LOADER_CHECKSUM_EN.
module pcfx_bios_loader #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int          MAX_BYTES_LOG2 = 20
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [19:0] size_words,
  output logic        overflow,
  output logic [15:0] checksum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [39:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [23:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [19:0]   size_q, size_d;
  logic          ovf_q, ovf_d;

  logic          clr, push, pop, drop;
  logic          idx_match, in_range, full;
  logic [19:0]   w;
  logic [20:0]   w_inc;
  logic [39:0]   push_ent;
  logic [39:0]   head;
  logic          unused_ok;

  assign idx_match = ioctl_index[5:0] <= 6'h01;
  assign in_range  = ioctl_addr < (25'd1 << (MAX_BYTES_LOG2 + 1));
  assign w         = ioctl_addr[20:1];
  assign w_inc     = {1'b0, w} + 21'd1;
  assign full      = cnt_q == CW'(FIFO_DEPTH);
  assign push_ent  = {BASE_ADDR + {4'd0, w}, ioctl_dout};
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = mem_req_q & mem_ack;
  assign unused_ok = &{1'b0, ioctl_index[7:6]};

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ioctl_download && idx_match) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        if (ioctl_wr && idx_match) begin
          if (!in_range || full) drop = 1'b1;
          else push = 1'b1;
        end
        if (!ioctl_download) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == '0 && !mem_req_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    ovf_d       = ovf_q | drop;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      size_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_inc > {1'b0, size_q}) size_d = w_inc[19:0];
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        mem_req_d = 1'b0;
      end
      cnt_d = cnt_q + {{PW{1'b0}}, push}
                    - {{PW{1'b0}}, pop};
      // An empty FIFO forwards the incoming word straight to the port.
      if (!mem_req_q) begin
        if (cnt_q != '0) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = head[39:16];
          mem_wdata_d = head[15:0];
        end else if (push) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = push_ent[39:16];
          mem_wdata_d = push_ent[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      size_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= push_ent;
  end

`ifdef PCFX_LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr) csum_d = '0;
    else if (push) csum_d = csum_q + ioctl_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = (cnt_q >= CW'(FIFO_DEPTH - 1))
                    | (state_q == DRAIN);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q == LOAD) | (state_q == DRAIN);
  assign done       = state_q == DONE;
  assign size_words = size_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pcfx_bios_loader.sv
// tb_pcfx_bios_loader: directed vectors and corner sequences
// for the BIOS download stage.
module tb_pcfx_bios_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] size_words;
  logic        overflow;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit ack_en = 1'b0;
  bit req_seen = 1'b0;
  bit prev_req = 1'b0;
  logic [23:0] prev_a = '0;
  logic [15:0] prev_d = '0;
  logic [23:0] log_a[$];
  logic [15:0] log_d[$];

  pcfx_bios_loader #(
    .FIFO_DEPTH(4),
    .BASE_ADDR(24'h010000),
    .MAX_BYTES_LOG2(20)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .busy(busy),
    .done(done),
    .size_words(size_words),
    .overflow(overflow),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // SDRAM model: ack one cycle after a request is first seen
  always @(negedge clk) begin
    if (ack_en && mem_req && req_seen && !mem_ack) mem_ack = 1'b1;
    else mem_ack = 1'b0;
    req_seen = mem_req;
  end

  always @(posedge clk) begin
    if (reset_n && mem_req && mem_ack) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reset_n && prev_req && mem_req) begin
      checks++;
      if (mem_addr !== prev_a || mem_wdata !== prev_d) begin
        errors++;
        $display("FAIL req_stable: got %h/%h required %h/%h",
                 mem_addr, mem_wdata, prev_a, prev_d);
      end
    end
    prev_req = mem_req;
    prev_a   = mem_addr;
    prev_d   = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    tick();
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic stop_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] csum_exp(input logic [15:0] v);
`ifdef PCFX_LOADER_CHECKSUM_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [15:0] data;
    bit          exp_write;
    logic [23:0] exp_maddr;
    logic [19:0] exp_size;
    bit          exp_ovf;
    bit          exp_busy;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base;
    vecs[0] = '{8'h00, 25'h0000000, 16'h5555, 1'b1, 24'h010000,
                20'h00001, 1'b0, 1'b1, 16'h5555};
    vecs[1] = '{8'h01, 25'h0000010, 16'h0F0F, 1'b1, 24'h010008,
                20'h00009, 1'b0, 1'b1, 16'h0F0F};
    vecs[2] = '{8'h41, 25'h01FFFFE, 16'hFFFF, 1'b1, 24'h10FFFF,
                20'h00000, 1'b0, 1'b1, 16'hFFFF};
    vecs[3] = '{8'h00, 25'h0200000, 16'h1111, 1'b0, 24'h000000,
                20'h00000, 1'b1, 1'b1, 16'h0000};
    vecs[4] = '{8'h02, 25'h0000000, 16'h2222, 1'b0, 24'h000000,
                20'h00000, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{8'h80, 25'h00000FE, 16'hA5A5, 1'b1, 24'h01007F,
                20'h00080, 1'b0, 1'b1, 16'hA5A5};
    vecs[6] = '{8'h03, 25'h0000004, 16'h3333, 1'b0, 24'h000000,
                20'h00080, 1'b0, 1'b0, 16'hA5A5};

    repeat (3) tick();
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_size", {12'd0, size_words}, 32'd0);
    chk("rst_csum", {16'd0, checksum}, 32'd0);
    reset_n = 1'b1;
    ack_en = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      log_a.delete();
      log_d.delete();
      base = done_cnt;
      start(vecs[i].idx);
      wr(vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_busy", i), {31'd0, busy},
          {31'd0, vecs[i].exp_busy});
      stop_dl();
      repeat (12) tick();
      chk($sformatf("v%0d_nwr", i), log_a.size(),
          {31'd0, vecs[i].exp_write});
      if (vecs[i].exp_write && log_a.size() > 0) begin
        chk($sformatf("v%0d_maddr", i), {8'd0, log_a[0]},
            {8'd0, vecs[i].exp_maddr});
        chk($sformatf("v%0d_mdata", i), {16'd0, log_d[0]},
            {16'd0, vecs[i].data});
      end
      chk($sformatf("v%0d_size", i), {12'd0, size_words},
          {12'd0, vecs[i].exp_size});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow},
          {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_done", i), done_cnt - base,
          {31'd0, vecs[i].exp_busy});
      chk($sformatf("v%0d_csum", i), {16'd0, checksum},
          {16'd0, csum_exp(vecs[i].exp_csum)});
    end

    // basic two-word load, request visible the cycle after the strobe
    log_a.delete();
    log_d.delete();
    base = done_cnt;
    start(8'h00);
    wr(25'h0, 16'h1234);
    chk("lat_req", {31'd0, mem_req}, 32'd1);
    chk("lat_addr", {8'd0, mem_addr}, 32'h010000);
    wr(25'h2, 16'hABCD);
    stop_dl();
    for (int i = 0; i < 30 && done_cnt == base; i++) tick();
    tick();
    chk("basic_nwr", log_a.size(), 32'd2);
    if (log_a.size() == 2) begin
      chk("basic_a0", {8'd0, log_a[0]}, 32'h010000);
      chk("basic_d0", {16'd0, log_d[0]}, 32'h1234);
      chk("basic_a1", {8'd0, log_a[1]}, 32'h010001);
      chk("basic_d1", {16'd0, log_d[1]}, 32'hABCD);
    end
    chk("basic_size", {12'd0, size_words}, 32'd2);
    chk("basic_done", done_cnt - base, 32'd1);
    chk("basic_csum", {16'd0, checksum},
        {16'd0, csum_exp(16'hBE01)});

    // backpressure and overrun with the SDRAM stalled
    log_a.delete();
    log_d.delete();
    base = done_cnt;
    ack_en = 1'b0;
    start(8'h00);
    wr(25'h0, 16'h1001);
    wr(25'h2, 16'h1002);
    chk("bp_wait2", {31'd0, ioctl_wait}, 32'd0);
    wr(25'h4, 16'h1003);
    chk("bp_wait3", {31'd0, ioctl_wait}, 32'd1);
    wr(25'h6, 16'h1004);
    chk("bp_ovf4", {31'd0, overflow}, 32'd0);
    chk("bp_wait4", {31'd0, ioctl_wait}, 32'd1);
    wr(25'h8, 16'h1005);
    chk("bp_ovf5", {31'd0, overflow}, 32'd1);
    stop_dl();
    ack_en = 1'b1;
    for (int i = 0; i < 40 && done_cnt == base; i++) tick();
    tick();
    chk("bp_nwr", log_a.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      chk($sformatf("bp_a%0d", i), {8'd0, log_a[i]},
          32'h010000 + i);
      chk($sformatf("bp_d%0d", i), {16'd0, log_d[i]},
          32'h1001 + i);
    end
    chk("bp_size", {12'd0, size_words}, 32'd4);
    chk("bp_done", done_cnt - base, 32'd1);
    chk("bp_csum", {16'd0, checksum},
        {16'd0, csum_exp(16'h400A)});

    // reset while a request is pending in DRAIN
    base = done_cnt;
    ack_en = 1'b0;
    start(8'h01);
    wr(25'h6, 16'h7777);
    stop_dl();
    chk("rd_req", {31'd0, mem_req}, 32'd1);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_wait", {31'd0, ioctl_wait}, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("rd_req0", {31'd0, mem_req}, 32'd0);
    chk("rd_busy0", {31'd0, busy}, 32'd0);
    chk("rd_size0", {12'd0, size_words}, 32'd0);
    chk("rd_wait0", {31'd0, ioctl_wait}, 32'd0);
    reset_n = 1'b1;
    repeat (8) tick();
    chk("rd_nodone", done_cnt - base, 32'd0);
    chk("rd_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
